// File: rtl/cordic_cmd_deframer.sv
// Command deframer between the UART RX and the CORDIC core: hunts for SYNC,
// assembles {SYNC, HI, LO, CHK}, verifies the XOR checksum and hands off the angle.
module cordic_cmd_deframer #(
   parameter int          DATA_W      = 16,
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int          TIMEOUT_CYC = 2000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   output logic [DATA_W-1:0] o_angle,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_chk_err,
   output logic              o_timeout,
   output logic              o_overrun,
   output logic [7:0]        o_err_cnt
);

   localparam int               CNT_W   = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MSB  = 3'd1,
      S_LSB  = 3'd2,
      S_CHK  = 3'd3,
      S_HOLD = 3'd4
   } state_e;

   function automatic logic [7:0] frame_chk(input logic [7:0] hi, input logic [7:0] lo);
      return SYNC_BYTE ^ hi ^ lo;
   endfunction

   state_e            state_q;
   logic [7:0]        hi_q;
   logic [7:0]        lo_q;
   logic [CNT_W-1:0]  tmo_cnt_q;
   logic [DATA_W-1:0] angle_q;
   logic              valid_q;
   logic              chk_err_q;
   logic              timeout_q;
   logic              overrun_q;
   logic [7:0]        err_cnt_q;

   logic in_frame_s;
   logic chk_bad_s;
   logic tmo_hit_s;
   logic ovr_s;
   logic err_s;

   // Error conditions of the current cycle; a byte always beats a timeout.
   always_comb begin
      in_frame_s = (state_q == S_MSB) || (state_q == S_LSB) || (state_q == S_CHK);
      chk_bad_s  = (state_q == S_CHK) && i_rx_valid && (i_rx_data != frame_chk(hi_q, lo_q));
      tmo_hit_s  = in_frame_s && !i_rx_valid && (tmo_cnt_q == CNT_MAX);
      ovr_s      = (state_q == S_HOLD) && i_rx_valid && !i_ready;
      err_s      = chk_bad_s || tmo_hit_s || ovr_s;
   end

   // Frame FSM with registered outputs, error pulses and saturating error count.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         hi_q      <= 8'h00;
         lo_q      <= 8'h00;
         tmo_cnt_q <= '0;
         angle_q   <= '0;
         valid_q   <= 1'b0;
         chk_err_q <= 1'b0;
         timeout_q <= 1'b0;
         overrun_q <= 1'b0;
         err_cnt_q <= 8'h00;
      end else begin
         chk_err_q <= chk_bad_s;
         timeout_q <= tmo_hit_s;
         overrun_q <= ovr_s;
         if (err_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
         case (state_q)
            S_IDLE: begin
               tmo_cnt_q <= '0;
               if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                  state_q <= S_MSB;
               end
            end
            S_MSB: begin
               if (i_rx_valid) begin
                  hi_q      <= i_rx_data;
                  tmo_cnt_q <= '0;
                  state_q   <= S_LSB;
               end else if (tmo_hit_s) begin
                  tmo_cnt_q <= '0;
                  state_q   <= S_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            S_LSB: begin
               if (i_rx_valid) begin
                  lo_q      <= i_rx_data;
                  tmo_cnt_q <= '0;
                  state_q   <= S_CHK;
               end else if (tmo_hit_s) begin
                  tmo_cnt_q <= '0;
                  state_q   <= S_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            S_CHK: begin
               if (i_rx_valid) begin
                  tmo_cnt_q <= '0;
                  if (chk_bad_s) begin
                     state_q <= S_IDLE;
                  end else begin
                     angle_q <= {hi_q, lo_q};
                     valid_q <= 1'b1;
                     state_q <= S_HOLD;
                  end
               end else if (tmo_hit_s) begin
                  tmo_cnt_q <= '0;
                  state_q   <= S_IDLE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            S_HOLD: begin
               tmo_cnt_q <= '0;
               // A byte coinciding with the handshake is judged as if in IDLE.
               if (i_ready) begin
                  valid_q <= 1'b0;
                  if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                     state_q <= S_MSB;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q   <= S_IDLE;
               valid_q   <= 1'b0;
               tmo_cnt_q <= '0;
            end
         endcase
      end
   end

   assign o_angle   = angle_q;
   assign o_valid   = valid_q;
   assign o_chk_err = chk_err_q;
   assign o_timeout = timeout_q;
   assign o_overrun = overrun_q;
   assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_cordic_cmd_deframer.sv
// Directed bench for cordic_cmd_deframer with an angle scoreboard.
module tb_cordic_cmd_deframer;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data  = 8'h00;
   logic        ready    = 1'b0;
   logic [15:0] angle;
   logic        valid;
   logic        chk_err;
   logic        timeout;
   logic        overrun;
   logic [7:0]  err_cnt;

   cordic_cmd_deframer dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rx_valid (rx_valid),
      .i_rx_data  (rx_data),
      .o_angle    (angle),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_chk_err  (chk_err),
      .o_timeout  (timeout),
      .o_overrun  (overrun),
      .o_err_cnt  (err_cnt)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int n_chk  = 0;
   int n_tmo  = 0;
   int n_ovr  = 0;
   int n_vcyc = 0;
   logic [15:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_chk(input logic [7:0] hi, input logic [7:0] lo);
      return 8'hA5 ^ hi ^ lo;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] ck);
      send_byte(8'hA5);
      send_byte(hi);
      send_byte(lo);
      send_byte(ck);
   endtask

   // Output monitor: counts pulses and scores each completed handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (chk_err) n_chk++;
         if (timeout) n_tmo++;
         if (overrun) n_ovr++;
         if (valid)   n_vcyc++;
         if (valid && ready) begin
            if (sb_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $error("FAIL unexpected_valid: observed angle %0h expected no transfer", angle);
            end else begin
               check("angle", {16'h0000, angle}, {16'h0000, sb_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of test expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int v0;
      int lat;
      bit seen;

      repeat (3) tick();
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_angle", {16'd0, angle}, 32'd0);
      check("rst_errcnt", {24'd0, err_cnt}, 32'd0);
      check("rst_pulses", {29'd0, chk_err, timeout, overrun}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: basic frame
      ready = 1'b1;
      v0 = n_vcyc;
      sb_q.push_back(16'h1234);
      send_frame(8'h12, 8'h34, 8'h83);
      repeat (3) tick();
      check("t1_valid_cycles", n_vcyc - v0, 32'd1);
      check("t1_no_errs", n_chk + n_tmo + n_ovr, 32'd0);
      check("t1_errcnt", {24'd0, err_cnt}, 32'd0);

      // 2: leading junk ignored
      v0 = n_vcyc;
      sb_q.push_back(16'hABCD);
      send_byte(8'h00);
      send_byte(8'hFF);
      send_frame(8'hAB, 8'hCD, ref_chk(8'hAB, 8'hCD));
      repeat (3) tick();
      check("t2_valid_cycles", n_vcyc - v0, 32'd1);
      check("t2_errcnt", {24'd0, err_cnt}, 32'd0);

      // 3: bad checksum, then good frame
      v0 = n_vcyc;
      send_frame(8'h12, 8'h34, 8'h84);
      repeat (2) tick();
      check("t3_chk_err", n_chk, 32'd1);
      check("t3_errcnt", {24'd0, err_cnt}, 32'd1);
      check("t3_no_valid", n_vcyc - v0, 32'd0);
      sb_q.push_back(16'h1234);
      send_frame(8'h12, 8'h34, 8'h83);
      repeat (3) tick();
      check("t3_valid_cycles", n_vcyc - v0, 32'd1);

      // long but legal inter-byte gap
      v0 = n_vcyc;
      sb_q.push_back(16'h5678);
      send_byte(8'hA5);
      send_byte(8'h56);
      repeat (1990) tick();
      send_byte(8'h78);
      send_byte(ref_chk(8'h56, 8'h78));
      repeat (3) tick();
      check("gap_no_timeout", n_tmo, 32'd0);
      check("gap_valid_cycles", n_vcyc - v0, 32'd1);

      // 4: timeout
      v0 = n_vcyc;
      send_byte(8'hA5);
      send_byte(8'h12);
      seen = 1'b0;
      lat = 0;
      for (int i = 1; i <= 2100 && !seen; i++) begin
         tick();
         if (timeout) begin
            seen = 1'b1;
            lat = i;
         end
      end
      check("t4_timeout_seen", {31'd0, seen}, 32'd1);
      check("t4_timeout_latency", {31'd0, (lat >= 1999 && lat <= 2001)}, 32'd1);
      send_byte(8'h34);
      send_byte(8'h83);
      repeat (3) tick();
      check("t4_no_valid", n_vcyc - v0, 32'd0);
      check("t4_errcnt", {24'd0, err_cnt}, 32'd2);

      // 5: overrun during hold, handshake with a coincident SYNC
      ready = 1'b0;
      sb_q.push_back(16'h1234);
      send_frame(8'h12, 8'h34, 8'h83);
      tick();
      check("t5_hold_valid", {31'd0, valid}, 32'd1);
      send_byte(8'h55);
      tick();
      check("t5_overrun", n_ovr, 32'd1);
      check("t5_hold_angle", {16'd0, angle}, 32'h1234);
      check("t5_still_valid", {31'd0, valid}, 32'd1);
      check("t5_errcnt", {24'd0, err_cnt}, 32'd3);
      ready = 1'b1;
      sb_q.push_back(16'h0010);
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(ref_chk(8'h00, 8'h10));
      repeat (3) tick();
      check("t5_sb_drained", sb_q.size(), 32'd0);

      // 6: reset during hold
      ready = 1'b0;
      sb_q.push_back(16'h1234);
      send_frame(8'h12, 8'h34, 8'h83);
      tick();
      check("t6_hold_valid", {31'd0, valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {31'd0, valid}, 32'd0);
      check("t6_rst_errcnt", {24'd0, err_cnt}, 32'd0);
      sb_q.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      ready = 1'b1;
      v0 = n_vcyc;
      sb_q.push_back(16'h1234);
      send_frame(8'h12, 8'h34, 8'h83);
      repeat (3) tick();
      check("t6_valid_cycles", n_vcyc - v0, 32'd1);
      check("t6_sb_drained", sb_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
